// File: rtl/game_pkg.sv
// Shared game constants, hold-FSM state encoding and clamp helper
// for the paddle/player position path.
package game_pkg;

  localparam int POS_W         = 10;
  localparam int SCREEN_HEIGHT = 768;
  localparam int SCREEN_WIDTH  = 1024;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } hold_state_e;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/hold_repeat.sv
// Button edge detect plus hold-to-repeat FSM; emits one-cycle
// up/down move events and a held flag.
module hold_repeat
  import game_pkg::*;
#(
  parameter int REPEAT_DELAY = 16_250_000,
  parameter int REPEAT_RATE  = 4_062_500,
  parameter int CNT_W        = 25
) (
  input  logic clock,
  input  logic reset_n,
  input  logic up,
  input  logic down,
  output logic ev_up,
  output logic ev_down,
  output logic held
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE - 1);

  hold_state_e      state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_up_q, prev_down_q;

  logic rise_up, rise_dn, both;
  logic dir_lvl, opp_rise, limit_hit;

  assign rise_up = up & ~prev_up_q;
  assign rise_dn = down & ~prev_down_q;
  assign both    = up & down;

  // dir_q: 1 = moving down, 0 = moving up
  assign dir_lvl   = dir_q ? down : up;
  assign opp_rise  = dir_q ? rise_up : rise_dn;
  assign limit_hit = (state_q == S_DELAY) ? (cnt_q == DLY_LAST)
                                          : (cnt_q == RPT_LAST);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    ev_up   = 1'b0;
    ev_down = 1'b0;
    if (both) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise_up | rise_dn) begin
            ev_up   = rise_up;
            ev_down = rise_dn;
            dir_d   = rise_dn;
            cnt_d   = '0;
            state_d = S_DELAY;
          end
        end
        default: begin
          if (opp_rise) begin
            ev_up   = dir_q;
            ev_down = ~dir_q;
            dir_d   = ~dir_q;
            cnt_d   = '0;
            state_d = S_DELAY;
          end else if (!dir_lvl) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (limit_hit) begin
            ev_up   = ~dir_q;
            ev_down = dir_q;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      prev_up_q   <= 1'b0;
      prev_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      prev_up_q   <= up;
      prev_down_q <= down;
    end
  end

  assign held = (state_q != S_IDLE);

endmodule

// File: rtl/player_pos_ctrl.sv
// Bounded player position: accumulates move events into a saturating
// delta and commits it only at frame boundaries; load forces position.
module player_pos_ctrl
  import game_pkg::*;
#(
  parameter int POS_W        = 10,
  parameter int MIN_POS      = 0,
  parameter int MAX_POS      = 767,
  parameter int INIT_POS     = 384,
  parameter int STEP         = 100,
  parameter int REPEAT_DELAY = 16_250_000,
  parameter int REPEAT_RATE  = 4_062_500,
  parameter int CNT_W        = 25
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             up,
  input  logic             down,
  input  logic             frame_start,
  input  logic             load,
  input  logic [POS_W-1:0] load_pos,
  output logic [POS_W-1:0] pos,
  output logic             pending,
  output logic             held
);

  localparam int RANGE = MAX_POS - MIN_POS;
  localparam int DW    = POS_W + 2;

  logic ev_up, ev_down;

  hold_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .CNT_W        (CNT_W)
  ) u_hold (
    .clock   (clock),
    .reset_n (reset_n),
    .up      (up),
    .down    (down),
    .ev_up   (ev_up),
    .ev_down (ev_down),
    .held    (held)
  );

  logic signed [DW-1:0] delta_q, delta_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 pending_q;
  int                   step_v, acc_base, acc_sum;

  // All arithmetic in 32-bit int so clamping never sees a wrapped value
  always_comb begin
    step_v   = ev_down ? STEP : (ev_up ? -STEP : 0);
    acc_base = frame_start ? 0 : int'(delta_q);
    acc_sum  = clamp(acc_base + step_v, -RANGE, RANGE);
    pos_d    = pos_q;
    delta_d  = DW'(acc_sum);
    if (load) begin
      pos_d   = POS_W'(clamp(int'(load_pos), MIN_POS, MAX_POS));
      delta_d = '0;
    end else if (frame_start) begin
      pos_d = POS_W'(clamp(int'(pos_q) + int'(delta_q), MIN_POS, MAX_POS));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pos_q     <= POS_W'(INIT_POS);
      delta_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      delta_q   <= delta_d;
      pending_q <= (delta_d != '0);
    end
  end

  assign pos     = pos_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_player_pos_ctrl.sv
// Self-checking bench for player_pos_ctrl: vector table, directed
// multi-cycle sequences and randomized run against a timing model.
module tb_player_pos_ctrl;

  localparam int D    = 20;
  localparam int R    = 5;
  localparam int STEP = 100;
  localparam int MINP = 0;
  localparam int MAXP = 767;
  localparam int INIT = 384;

  logic       clock = 1'b0;
  logic       reset_n, up, down, frame_start, load;
  logic [9:0] load_pos, pos;
  logic       pending, held;

  player_pos_ctrl #(
    .POS_W(10), .MIN_POS(MINP), .MAX_POS(MAXP), .INIT_POS(INIT),
    .STEP(STEP), .REPEAT_DELAY(D), .REPEAT_RATE(R), .CNT_W(25)
  ) dut (
    .clock(clock), .reset_n(reset_n), .up(up), .down(down),
    .frame_start(frame_start), .load(load), .load_pos(load_pos),
    .pos(pos), .pending(pending), .held(held)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: events derived from time elapsed since press
  bit m_active, m_dir, m_pu, m_pd;
  int m_t0, m_now, m_delta, m_pos;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_step();
    bit eu, ed;
    int t, mv;
    eu = 0; ed = 0;
    if (!reset_n) begin
      m_pos = INIT; m_delta = 0; m_active = 0;
      m_pu = 0; m_pd = 0; m_now++;
      return;
    end
    if (up && down) begin
      m_active = 0;
    end else if (!m_active) begin
      if (up && !m_pu) begin
        eu = 1; m_active = 1; m_dir = 0; m_t0 = m_now;
      end else if (down && !m_pd) begin
        ed = 1; m_active = 1; m_dir = 1; m_t0 = m_now;
      end
    end else if (m_dir ? (up && !m_pu) : (down && !m_pd)) begin
      m_dir = ~m_dir; m_t0 = m_now;
      eu = !m_dir; ed = m_dir;
    end else if (!(m_dir ? down : up)) begin
      m_active = 0;
    end else begin
      t = m_now - m_t0;
      if (t == D || (t > D && (t - D) % R == 0)) begin
        eu = !m_dir; ed = m_dir;
      end
    end
    mv = ed ? STEP : (eu ? -STEP : 0);
    if (load) begin
      m_pos = clampi(int'(load_pos), MINP, MAXP);
      m_delta = 0;
    end else if (frame_start) begin
      m_pos = clampi(m_pos + m_delta, MINP, MAXP);
      m_delta = clampi(mv, -(MAXP - MINP), MAXP - MINP);
    end else begin
      m_delta = clampi(m_delta + mv, -(MAXP - MINP), MAXP - MINP);
    end
    m_pu = up; m_pd = down; m_now++;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0; up = 0; down = 0;
    frame_start = 0; load = 0;
    cyc();
    reset_n = 1;
  endtask

  typedef struct {
    logic u, d, fs, ld;
    int   lp, ep;
    logic epd, eh;
  } vec_t;

  vec_t tbl[22];

  typedef struct { int n; int ep; } hold_t;
  hold_t hv[5];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0,   384, 1, 1};
    tbl[1]  = '{0, 0, 1, 0, 0,   284, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0,   284, 1, 1};
    tbl[3]  = '{0, 0, 1, 0, 0,   184, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0,   184, 1, 1};
    tbl[5]  = '{0, 0, 1, 0, 0,   84,  0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0,   84,  1, 1};
    tbl[7]  = '{0, 0, 1, 0, 0,   0,   0, 0};
    tbl[8]  = '{1, 0, 0, 0, 0,   0,   1, 1};
    tbl[9]  = '{0, 0, 1, 0, 0,   0,   0, 0};
    tbl[10] = '{0, 1, 0, 0, 0,   0,   1, 1};
    tbl[11] = '{0, 1, 1, 0, 0,   100, 0, 1};
    tbl[12] = '{1, 0, 0, 0, 0,   100, 1, 1};
    tbl[13] = '{1, 1, 0, 0, 0,   100, 1, 0};
    tbl[14] = '{0, 0, 1, 0, 0,   0,   0, 0};
    tbl[15] = '{0, 0, 0, 1, 900, 767, 0, 0};
    tbl[16] = '{1, 0, 0, 1, 50,  50,  0, 1};
    tbl[17] = '{0, 0, 0, 0, 0,   50,  0, 0};
    tbl[18] = '{1, 1, 0, 0, 0,   50,  0, 0};
    tbl[19] = '{0, 0, 0, 0, 0,   50,  0, 0};
    tbl[20] = '{0, 1, 1, 0, 0,   50,  1, 1};
    tbl[21] = '{0, 0, 1, 0, 0,   150, 0, 0};
    hv[0] = '{20, 484};
    hv[1] = '{21, 584};
    hv[2] = '{25, 584};
    hv[3] = '{26, 684};
    hv[4] = '{41, 767};

    load_pos = '0;
    m_now = 0; m_t0 = 0; m_dir = 0;
    reset_n = 0; up = 0; down = 0; frame_start = 0; load = 0;
    cyc(); cyc();
    chk("reset_pos", int'(pos), INIT);
    chk("reset_pending", int'(pending), 0);
    chk("reset_held", int'(held), 0);

    reset_n = 1;
    up = 1;
    repeat (3) cyc();
    chk("press_held", int'(held), 1);
    chk("press_pending", int'(pending), 1);
    up = 0; frame_start = 1;
    cyc();
    frame_start = 0;
    chk("press_pos", int'(pos), 284);
    chk("press_pending_clr", int'(pending), 0);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      up = tbl[i].u; down = tbl[i].d;
      frame_start = tbl[i].fs; load = tbl[i].ld;
      load_pos = 10'(tbl[i].lp);
      cyc();
      chk($sformatf("vec%0d_pos", i), int'(pos), tbl[i].ep);
      chk($sformatf("vec%0d_pending", i), int'(pending), int'(tbl[i].epd));
      chk($sformatf("vec%0d_held", i), int'(held), int'(tbl[i].eh));
    end
    up = 0; down = 0; frame_start = 0; load = 0;

    // press at edge k, then n-1 further held edges before release
    for (int i = 0; i < 5; i++) begin
      do_reset();
      down = 1;
      repeat (hv[i].n) cyc();
      chk($sformatf("hold%0d_held", hv[i].n), int'(held), 1);
      down = 0; frame_start = 1;
      cyc();
      frame_start = 0;
      chk($sformatf("hold%0d_pos", hv[i].n), int'(pos), hv[i].ep);
    end

    do_reset();
    up = 1; cyc(); up = 0; cyc();
    up = 1; cyc(); up = 0; cyc();
    chk("ld_pending_pre", int'(pending), 1);
    load = 1; frame_start = 1; load_pos = 10'd300;
    cyc();
    load = 0;
    chk("ld_fs_pos", int'(pos), 300);
    chk("ld_fs_pending", int'(pending), 0);
    cyc();
    frame_start = 0;
    chk("ld_fs_next_pos", int'(pos), 300);

    do_reset();
    down = 1;
    repeat (30) cyc();
    chk("mid_rpt_held", int'(held), 1);
    reset_n = 0; down = 0;
    cyc();
    chk("mid_rpt_rst_pos", int'(pos), INIT);
    chk("mid_rpt_rst_held", int'(held), 0);
    chk("mid_rpt_rst_pend", int'(pending), 0);
    reset_n = 1;

    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 23) == 0) up = ~up;
      if ($urandom_range(0, 29) == 0) down = ~down;
      frame_start = ($urandom_range(0, 39) == 0);
      load = ($urandom_range(0, 149) == 0);
      load_pos = 10'($urandom);
      reset_n = ($urandom_range(0, 999) != 0);
      cyc();
      chk($sformatf("rnd%0d_pos", n), int'(pos), m_pos);
      chk($sformatf("rnd%0d_pending", n), int'(pending), int'(m_delta != 0));
      chk($sformatf("rnd%0d_held", n), int'(held), int'(m_active));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
